sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Upstream conditioning stage for the board slide switches, between the raw `i_sw` pins and the speed-select input of the LED-shift counter.
- Synchronises each switch bit into the `clock` domain and rejects bounce with a per-bit stability counter.
- Outputs a clean switch vector plus single-cycle rise, fall and any-change pulses, so downstream logic can restart its count when the speed selection changes.

Parameters:
- NB_SW, 4, number of switch bits.
- NB_DEBOUNCE, 20, width of each per-bit stability counter.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level. Must satisfy 2 <= DEBOUNCE_CYCLES <= 2^NB_DEBOUNCE - 1; elaboration error otherwise.

Ports:
- clock  input  1  system clock, all state on rising edge.
- i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_sw  input  NB_SW  raw, asynchronous, bouncing switch levels.
- o_sw  output  NB_SW  debounced switch levels, registered.
- o_sw_rise  output  NB_SW  per-bit one-cycle pulse on an accepted 0->1 change.
- o_sw_fall  output  NB_SW  per-bit one-cycle pulse on an accepted 1->0 change.
- o_changed  output  1  one-cycle pulse when any bit of o_sw changes.

Behaviour:
- Reset (i_reset=0, asynchronous): both synchroniser stages, o_sw, o_sw_rise, o_sw_fall, o_changed and all counters go to 0; every bit FSM goes to STABLE. Outputs stay 0 while reset is held.
- Synchroniser: two flops per bit, sync1 <= i_sw, sync2 <= sync1. No other logic touches i_sw.
- Per-bit FSM, states STABLE and CHECKING:
  - STABLE, sync2 == o_sw[i]: hold, cnt = 0.
  - STABLE, sync2 != o_sw[i]: go to CHECKING, cnt <= 0.
  - CHECKING, sync2 == o_sw[i]: bounce rejected; return to STABLE, cnt <= 0, no pulse.
  - CHECKING, sync2 != o_sw[i], cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - CHECKING, sync2 != o_sw[i], cnt == DEBOUNCE_CYCLES-1: o_sw[i] <= sync2, pulse, return to STABLE, cnt <= 0.
- Pulses:
  - o_sw_rise[i] / o_sw_fall[i] are registered and high for exactly the one cycle after the edge where o_sw[i] changes.
  - o_changed is registered on the same edge and equals the OR of all rise|fall conditions.
  - All pulses are 0 in every other cycle.
- Latency: edge 0 is the first rising edge whose sync1 samples the new level. With the input held stable, o_sw[i] updates on edge DEBOUNCE_CYCLES+2. Any reversion before that edge restarts qualification from STABLE.
- Counter never wraps; its maximum value is DEBOUNCE_CYCLES-1.
- Bits are fully independent. Several bits may qualify on the same edge; each raises its own rise/fall bit and o_changed is a single pulse.
- Reset mid-qualification: the qualification is discarded and o_sw returns to 0.
- Switch held high through reset release: it qualifies as a normal 0->1 change, with o_sw_rise pulsing DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge. This is intended, so downstream logic sees the initial setting.
- No combinational path from any input to any output.

Decomposition:
- Shared package sw_debounce_pkg holds:
  - FSM state encoding: ST_STABLE = 1'b0, ST_CHECKING = 1'b1.
  - Default constants for NB_SW, NB_DEBOUNCE and DEBOUNCE_CYCLES, so the top level and benches agree.
- One sub-module, debounce_bit: synchroniser, FSM and counter for a single bit, with outputs level, rise and fall.
- sw_debounce instantiates NB_SW copies in a generate loop and registers the o_changed OR.

Test Plan (DEBOUNCE_CYCLES=8, NB_DEBOUNCE=4, NB_SW=4):
- Reset check: hold i_reset=0 with i_sw=4'hF, then release. All outputs are 0 during reset; o_sw=4'hF and o_sw_rise=4'hF appear on post-release edge 10; o_changed pulses once, on that edge only.
- Clean change: i_sw[0] goes 0->1 and is held. o_sw[0]=1 at edge 10, not edge 9; o_sw_rise[0] is high for one cycle; o_sw_fall=0 throughout.
- Bounce rejection: i_sw[1] toggles 1,0,1,0 every 3 cycles, then rests at 1. No output activity during toggling; o_sw[1] rises exactly 10 edges after the final 0->1 sample.
- Glitch shorter than threshold: i_sw[2]=1 for 7 cycles, then back to 0. o_sw, o_sw_rise, o_sw_fall and o_changed all stay 0.
- Simultaneous events: i_sw changes 4'b0011->4'b1100 in one cycle. At edge 10, o_sw=4'b1100, o_sw_rise=4'b1100 and o_sw_fall=4'b0011 together, with a single o_changed pulse.
- Reset mid-operation: assert i_reset=0 at edge 5 of a qualification. Outputs clear immediately (asynchronously); after release, qualification restarts from edge 0 and no pulse appears from the aborted attempt.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sw_debounce_pkg
// Shared definitions for the slide-switch debouncer:
//   - bit_state_t : per-bit qualification FSM encoding
//   - DEF_*       : default sizing constants used by the top level and benches
// ---------------------------------------------------------------------------
package sw_debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHECKING = 1'b1
  } bit_state_t;

  localparam int DEF_NB_SW           = 4;
  localparam int DEF_NB_DEBOUNCE     = 20;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// Synchroniser, stability FSM and counter for one switch bit.
// Ports:
//   clock   : system clock, rising edge
//   i_reset : asynchronous active-low reset
//   sw      : raw asynchronous switch level
//   level   : debounced level (registered)
//   rise    : one-cycle pulse after an accepted 0->1 change (registered)
//   fall    : one-cycle pulse after an accepted 1->0 change (registered)
//   accept  : combinational, high in the cycle whose closing edge updates
//             level; feeds the registered any-change pulse in the top level
// ---------------------------------------------------------------------------
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int NB_DEBOUNCE     = DEF_NB_DEBOUNCE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic i_reset,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam logic [NB_DEBOUNCE-1:0] CNT_MAX = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_DEBOUNCE-1:0] CNT_ONE = NB_DEBOUNCE'(1);

  logic                   sync_p0;
  logic                   sync_p1;
  bit_state_t             state;
  logic [NB_DEBOUNCE-1:0] cnt;

  assign accept = (state == ST_CHECKING) && (sync_p1 != level) && (cnt == CNT_MAX);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      state   <= ST_STABLE;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser, nothing else reads sw
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
      // stage p1 -> level: qualification FSM
      rise    <= 1'b0;
      fall    <= 1'b0;
      case (state)
        ST_STABLE: begin
          cnt <= '0;
          if (sync_p1 != level) state <= ST_CHECKING;
        end
        ST_CHECKING: begin
          if (sync_p1 == level) begin
            // reverted before qualifying: drop the attempt silently
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            level <= sync_p1;
            rise  <= sync_p1;
            fall  <= ~sync_p1;
            state <= ST_STABLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Debounces a vector of slide switches and reports accepted changes.
// Ports:
//   clock     : system clock, rising edge
//   i_reset   : asynchronous active-low reset
//   i_sw      : raw switch levels [NB_SW]
//   o_sw      : debounced switch levels [NB_SW], registered
//   o_sw_rise : per-bit one-cycle pulse on accepted 0->1 [NB_SW]
//   o_sw_fall : per-bit one-cycle pulse on accepted 1->0 [NB_SW]
//   o_changed : one-cycle pulse when any bit of o_sw changes
// ---------------------------------------------------------------------------
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int NB_SW           = DEF_NB_SW,
  parameter int NB_DEBOUNCE     = DEF_NB_DEBOUNCE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_sw_rise,
  output logic [NB_SW-1:0] o_sw_fall,
  output logic             o_changed
);

  // The counter must be able to reach DEBOUNCE_CYCLES-1 without wrapping.
  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > ((1 << NB_DEBOUNCE) - 1))) begin : g_bad_cfg
    $error("sw_debounce: DEBOUNCE_CYCLES out of range for NB_DEBOUNCE");
  end

  logic [NB_SW-1:0] accept;

  for (genvar i = 0; i < NB_SW; i++) begin : g_bit
    debounce_bit #(
      .NB_DEBOUNCE     (NB_DEBOUNCE),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clock   (clock),
      .i_reset (i_reset),
      .sw      (i_sw[i]),
      .level   (o_sw[i]),
      .rise    (o_sw_rise[i]),
      .fall    (o_sw_fall[i]),
      .accept  (accept[i])
    );
  end

  // Registered on the same edge as the per-bit pulses so all align.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) o_changed <= 1'b0;
    else          o_changed <= |accept;
  end

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  localparam int NSW = 4;
  localparam int NBD = 4;
  localparam int DC  = 8;

  logic           clock = 1'b0;
  logic           i_reset;
  logic [NSW-1:0] i_sw;
  logic [NSW-1:0] o_sw, o_sw_rise, o_sw_fall;
  logic           o_changed;

  sw_debounce #(.NB_SW(NSW), .NB_DEBOUNCE(NBD), .DEBOUNCE_CYCLES(DC)) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_sw      (i_sw),
    .o_sw      (o_sw),
    .o_sw_rise (o_sw_rise),
    .o_sw_fall (o_sw_fall),
    .o_changed (o_changed)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference: raw samples pass a 2-deep delay line; a bit's level flips once
  // the delayed sample has disagreed with it on DC+1 consecutive edges.
  logic [NSW-1:0] m_d1, m_d2, m_lvl, m_rise, m_fall;
  logic           m_chg;
  int             m_run [NSW];

  int cnt_r, cnt_f, cnt_c;

  typedef struct {
    logic [NSW-1:0] sw;
    int             hold;
    logic [NSW-1:0] exp_sw;
    int             exp_rise;
    int             exp_fall;
    int             exp_chg;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
    for (int i = 0; i < NSW; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [NSW-1:0] smp);
    logic [NSW-1:0] seen;
    seen   = m_d2;
    m_d2   = m_d1;
    m_d1   = smp;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < NSW; i++) begin
      if (seen[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DC + 1) begin
          m_lvl[i] = seen[i];
          if (seen[i]) m_rise[i] = 1'b1;
          else         m_fall[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_chg = |(m_rise | m_fall);
  endtask

  function automatic logic [15:0] outs();
    return {3'b000, o_sw, o_sw_rise, o_sw_fall, o_changed};
  endfunction

  task automatic step();
    logic [NSW-1:0] smp;
    smp = i_sw;
    @(posedge clock);
    if (!i_reset) model_clear();
    else          model_edge(smp);
    #1;
    cnt_r += $countones(o_sw_rise);
    cnt_f += $countones(o_sw_fall);
    cnt_c += int'(o_changed);
    chk("model", outs(), {3'b000, m_lvl, m_rise, m_fall, m_chg});
  endtask

  // Edge-exact check of one qualification starting with the next edge as edge 0.
  task automatic run_edges(input logic [NSW-1:0] old_sw, input logic [NSW-1:0] new_sw,
                           input logic [NSW-1:0] er, input logic [NSW-1:0] ef);
    for (int e = 0; e < 12; e++) begin
      step();
      chk("edge_lvl",  16'(o_sw),      16'((e >= DC + 2) ? new_sw : old_sw));
      chk("edge_rise", 16'(o_sw_rise), 16'((e == DC + 2) ? er : '0));
      chk("edge_fall", 16'(o_sw_fall), 16'((e == DC + 2) ? ef : '0));
      chk("edge_chg",  16'(o_changed), 16'(e == DC + 2));
    end
  endtask

  initial begin
    tbl[0] = '{sw: 4'b0000, hold: 12, exp_sw: 4'b0000, exp_rise: 0, exp_fall: 4, exp_chg: 1};
    tbl[1] = '{sw: 4'b0001, hold: 12, exp_sw: 4'b0001, exp_rise: 1, exp_fall: 0, exp_chg: 1};
    tbl[2] = '{sw: 4'b0101, hold: 7,  exp_sw: 4'b0001, exp_rise: 0, exp_fall: 0, exp_chg: 0};
    tbl[3] = '{sw: 4'b0001, hold: 12, exp_sw: 4'b0001, exp_rise: 0, exp_fall: 0, exp_chg: 0};
    tbl[4] = '{sw: 4'b0011, hold: 12, exp_sw: 4'b0011, exp_rise: 1, exp_fall: 0, exp_chg: 1};
    tbl[5] = '{sw: 4'b1100, hold: 12, exp_sw: 4'b1100, exp_rise: 2, exp_fall: 2, exp_chg: 1};
    tbl[6] = '{sw: 4'b1100, hold: 5,  exp_sw: 4'b1100, exp_rise: 0, exp_fall: 0, exp_chg: 0};

    cnt_r = 0; cnt_f = 0; cnt_c = 0;
    i_reset = 1'b1;
    i_sw    = '0;
    model_clear();
    #2;
    i_reset = 1'b0;
    i_sw    = 4'hF;
    #1;
    chk("rst_assert", outs(), 16'h0000);

    // Switches high through reset: outputs stay 0, then qualify as a rise.
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_hold", outs(), 16'h0000);
    end
    i_reset = 1'b1;
    run_edges(4'h0, 4'hF, 4'hF, 4'h0);

    for (int v = 0; v < 7; v++) begin
      cnt_r = 0; cnt_f = 0; cnt_c = 0;
      i_sw = tbl[v].sw;
      repeat (tbl[v].hold) step();
      chk("tbl_sw",   16'(o_sw),  16'(tbl[v].exp_sw));
      chk("tbl_rise", 16'(cnt_r), 16'(tbl[v].exp_rise));
      chk("tbl_fall", 16'(cnt_f), 16'(tbl[v].exp_fall));
      chk("tbl_chg",  16'(cnt_c), 16'(tbl[v].exp_chg));
    end

    // Clean single-bit change, then all four bits moving on the same edge.
    i_sw = 4'b1101;
    run_edges(4'b1100, 4'b1101, 4'b0001, 4'b0000);
    i_sw = 4'b0010;
    run_edges(4'b1101, 4'b0010, 4'b0010, 4'b1101);

    // Bounce on bit 1: quiet while toggling, full delay after final rise.
    i_sw = 4'b0000;
    repeat (12) step();
    for (int k = 0; k < 4; k++) begin
      i_sw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (3) begin
        step();
        chk("bounce_quiet", outs(), 16'h0000);
      end
    end
    i_sw = 4'b0010;
    run_edges(4'b0000, 4'b0010, 4'b0010, 4'b0000);

    // Reset at edge 5 of a qualification.
    i_sw = 4'b1111;
    repeat (6) step();
    #2;
    i_reset = 1'b0;
    model_clear();
    #1;
    chk("rst_async", outs(), 16'h0000);
    repeat (2) step();
    i_reset = 1'b1;
    run_edges(4'b0000, 4'b1111, 4'b1111, 4'b0000);

    // Random segments, occasional async reset.
    for (int s = 0; s < 400; s++) begin
      i_sw = NSW'($urandom_range(0, 15));
      repeat ($urandom_range(1, 14)) step();
      if ($urandom_range(0, 19) == 0) begin
        #2;
        i_reset = 1'b0;
        model_clear();
        #1;
        chk("rnd_rst", outs(), 16'h0000);
        step();
        i_reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
